// File: rtl/spart_pkg.sv
// Shared types, bus address map and baud/divisor helpers for the SPART echo driver.
package spart_pkg;

  typedef enum logic [2:0] {
    ST_INIT_LO,
    ST_INIT_HI,
    ST_HOLD,
    ST_IDLE,
    ST_READ,
    ST_WRITE
  } state_t;

  localparam logic [1:0] ADDR_DATA   = 2'b00;
  localparam logic [1:0] ADDR_STATUS = 2'b01;
  localparam logic [1:0] ADDR_DIV_LO = 2'b10;
  localparam logic [1:0] ADDR_DIV_HI = 2'b11;

  localparam int BAUD_TAB [4] = '{4800, 9600, 19200, 38400};

  // Rounded divisor for a 16x oversampling receiver.
  function automatic logic [15:0] div_for(input int clk_hz, input int baud);
    longint c;
    longint b;
    longint q;
    c = longint'(clk_hz);
    b = longint'(baud);
    q = (c + b * 8) / (b * 16) - 1;
    return q[15:0];
  endfunction

endpackage

// File: rtl/spart_fifo_driver_if.sv
// Control/handshake bundle between the echo driver (master) and the SPART (slave).
interface spart_fifo_driver_if;
  logic       rda;
  logic       tbr;
  logic       iocs;
  logic       iorw;
  logic [1:0] ioaddr;

  modport master (input rda, input tbr, output iocs, output iorw, output ioaddr);
  modport slave  (output rda, output tbr, input iocs, input iorw, input ioaddr);
endinterface

// File: rtl/spart_byte_fifo.sv
// Synchronous byte FIFO; pointers carry a wrap bit so full and empty are exact.
module spart_byte_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic                    pop,
  input  logic [7:0]              din,
  output logic [7:0]              head,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  count
);
  localparam int AW = $clog2(DEPTH);

  logic [7:0]  mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full)  wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= din;
  end

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count = wr_ptr - rd_ptr;
  assign head  = mem[rd_ptr[AW-1:0]];
endmodule

// File: rtl/spart_fifo_driver.sv
// SPART bus master: programs the baud divisor, then echoes received bytes via a FIFO.
// Define BR_RECONFIG_EN to reprogram the divisor whenever br_cfg changes while idle.
module spart_fifo_driver
  import spart_pkg::*;
#(
  parameter int CLK_HZ     = 100_000_000,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [1:0]                   br_cfg,
  spart_fifo_driver_if.master          sp,
  inout  wire  [7:0]                   databus,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
  output logic                         init_done
);
  localparam logic [15:0] DIV_TAB [4] = '{
    div_for(CLK_HZ, BAUD_TAB[0]), div_for(CLK_HZ, BAUD_TAB[1]),
    div_for(CLK_HZ, BAUD_TAB[2]), div_for(CLK_HZ, BAUD_TAB[3])
  };

  state_t      state, state_nxt, ret, ret_nxt;
  logic [1:0]  cfg_q, cfg_nxt;
  logic        last_rd, last_rd_nxt, done_nxt;
  logic        iocs_q, iorw_q, acc_nxt, rw_nxt;
  logic [1:0]  ioaddr_q, addr_nxt;
  logic [7:0]  dout_q, dout_nxt, fifo_head;
  logic        fifo_full, fifo_empty, can_rd, can_wr, reprog;
  logic [15:0] div_cur;

  spart_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (state == ST_READ),
    .pop   (state == ST_WRITE),
    .din   (databus),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign can_rd = sp.rda && !fifo_full;
  assign can_wr = sp.tbr && !fifo_empty;

`ifdef BR_RECONFIG_EN
  assign reprog = (br_cfg != cfg_q);
`else
  assign reprog = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_HOLD;
      ret       <= ST_INIT_LO;
      cfg_q     <= br_cfg;
      last_rd   <= 1'b0;
      init_done <= 1'b0;
      iocs_q    <= 1'b0;
      iorw_q    <= 1'b1;
      ioaddr_q  <= ADDR_DATA;
    end else begin
      state     <= state_nxt;
      ret       <= ret_nxt;
      cfg_q     <= cfg_nxt;
      last_rd   <= last_rd_nxt;
      init_done <= done_nxt;
      iocs_q    <= acc_nxt;
      iorw_q    <= rw_nxt;
      ioaddr_q  <= addr_nxt;
    end
  end

  always_ff @(posedge clk) begin
    dout_q <= dout_nxt;
  end

  always_comb begin
    state_nxt   = state;
    ret_nxt     = ret;
    cfg_nxt     = cfg_q;
    last_rd_nxt = last_rd;
    done_nxt    = init_done;
    case (state)
      ST_INIT_LO: begin state_nxt = ST_HOLD; ret_nxt = ST_INIT_HI; end
      ST_INIT_HI: begin state_nxt = ST_HOLD; ret_nxt = ST_IDLE; done_nxt = 1'b1; end
      ST_HOLD:    state_nxt = ret;
      ST_READ:    begin state_nxt = ST_HOLD; ret_nxt = ST_IDLE; last_rd_nxt = 1'b1; end
      ST_WRITE:   begin state_nxt = ST_HOLD; ret_nxt = ST_IDLE; last_rd_nxt = 1'b0; end
      ST_IDLE: begin
        // Reprogramming outranks data traffic; otherwise alternate when both sides are ready.
        if (reprog) begin
          cfg_nxt   = br_cfg;
          state_nxt = ST_INIT_LO;
        end else if (can_rd && (!can_wr || !last_rd)) begin
          state_nxt = ST_READ;
        end else if (can_wr) begin
          state_nxt = ST_WRITE;
        end
      end
      default: begin state_nxt = ST_HOLD; ret_nxt = ST_INIT_LO; end
    endcase

    div_cur  = DIV_TAB[cfg_nxt];
    acc_nxt  = 1'b1;
    rw_nxt   = 1'b0;
    addr_nxt = ADDR_DATA;
    dout_nxt = fifo_head;
    case (state_nxt)
      ST_INIT_LO: begin addr_nxt = ADDR_DIV_LO; dout_nxt = div_cur[7:0]; end
      ST_INIT_HI: begin addr_nxt = ADDR_DIV_HI; dout_nxt = div_cur[15:8]; end
      ST_WRITE:   rw_nxt = 1'b0;
      ST_READ:    rw_nxt = 1'b1;
      default: begin acc_nxt = 1'b0; rw_nxt = 1'b1; end
    endcase
  end

  assign sp.iocs   = iocs_q;
  assign sp.iorw   = iorw_q;
  assign sp.ioaddr = ioaddr_q;
  assign databus   = (iocs_q && !iorw_q) ? dout_q : 8'hzz;
endmodule

// File: tb/tb_spart_fifo_driver.sv
// Directed and randomized bench for spart_fifo_driver with a queue-based SPART/FIFO model.
module tb_spart_fifo_driver;
  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] br_cfg;
  wire  [7:0] databus;
  logic [3:0] fifo_count;
  logic       init_done;
  logic [7:0] rd_byte;

  spart_fifo_driver_if bus ();

  spart_fifo_driver #(.CLK_HZ(100_000_000), .FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .br_cfg     (br_cfg),
    .sp         (bus),
    .databus    (databus),
    .fifo_count (fifo_count),
    .init_done  (init_done)
  );

  always #5 clk = ~clk;
  assign databus = (bus.iocs && bus.iorw) ? rd_byte : 8'hzz;

  int compared = 0;
  int mismatched = 0;

  logic [7:0] rx_q [$];
  logic [7:0] exp_q [$];
  logic [7:0] out_log [$];
  logic [9:0] init_log [$];
  bit         acc_log [$];
  bit         rd_pend, wr_pend, prev_iocs, tbr_en, saw;
  int         tx_busy, busy_max;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock of the SPART + FIFO reference model.
  task automatic cyc();
    bit rda_old, tbr_old, just_rd, just_wr;
    rda_old = bus.rda;
    tbr_old = bus.tbr;
    @(posedge clk);
    #1;
    just_rd = 1'b0;
    just_wr = 1'b0;
    if (rst) begin
      rd_pend = 1'b0; wr_pend = 1'b0; prev_iocs = 1'b0; tx_busy = 0;
      exp_q.delete();
    end else begin
      if (rd_pend) begin exp_q.push_back(rx_q.pop_front()); rd_pend = 1'b0; just_rd = 1'b1; end
      if (wr_pend) begin out_log.push_back(exp_q.pop_front()); wr_pend = 1'b0; just_wr = 1'b1; end
    end
    chk("count", 32'(fifo_count), exp_q.size());
    if (bus.iocs) begin
      chk("hold_gap", 32'(prev_iocs), 0);
      if (bus.iorw) begin
        chk("rd_addr", 32'(bus.ioaddr), 0);
        chk("rd_rda", 32'(rda_old), 1);
        chk("rd_notfull", 32'(exp_q.size() < DEPTH), 1);
        chk("rd_avail", 32'(rx_q.size() > 0), 1);
        if (rx_q.size() > 0) rd_pend = 1'b1;
        acc_log.push_back(1'b1);
      end else if (bus.ioaddr == 2'b00) begin
        chk("wr_tbr", 32'(tbr_old), 1);
        chk("wr_notempty", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          chk("wr_data", 32'(databus), 32'(exp_q[0]));
          wr_pend = 1'b1;
        end
        acc_log.push_back(1'b0);
      end else begin
        init_log.push_back({bus.ioaddr, databus});
      end
    end
    prev_iocs = bus.iocs;
    // Flags lag one cycle after an access, like the real SPART.
    if (!just_rd) bus.rda = (rx_q.size() > 0);
    if (just_wr) tx_busy = (busy_max > 0) ? int'($urandom_range(busy_max)) : 0;
    else if (tx_busy > 0) begin bus.tbr = 1'b0; tx_busy--; end
    else bus.tbr = tbr_en;
    rd_byte = (rx_q.size() > 0) ? rx_q[0] : 8'hEE;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic wait_count(input int target, input int limit);
    for (int i = 0; i < limit && int'(fifo_count) != target; i++) cyc();
  endtask

  task automatic wait_out(input int n, input int limit);
    for (int i = 0; i < limit && out_log.size() < n; i++) cyc();
  endtask

  task automatic chk_init(input string tag, input logic [9:0] lo, input logic [9:0] hi);
    chk({tag, "_n"}, init_log.size(), 2);
    if (init_log.size() == 2) begin
      chk({tag, "_lo"}, 32'(init_log[0]), 32'(lo));
      chk({tag, "_hi"}, 32'(init_log[1]), 32'(hi));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; br_cfg = 2'd1; bus.rda = 1'b0; bus.tbr = 1'b0; rd_byte = 8'hEE;
    tbr_en = 1'b0; busy_max = 0; tx_busy = 0; rd_pend = 0; wr_pend = 0; prev_iocs = 0;

    // Reset values, then divisor programming for 9600 baud
    run(3);
    chk("rst_iocs", 32'(bus.iocs), 0);
    chk("rst_iorw", 32'(bus.iorw), 1);
    chk("rst_addr", 32'(bus.ioaddr), 0);
    chk("rst_done", 32'(init_done), 0);
    rst = 1'b0;
    init_log.delete();
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("init_done_t", 32'(init_done), (i == 3) ? 1 : 0);
    end
    chk_init("init9600", 10'h28A, 10'h302);

    // Single byte echo
    rx_q.push_back(8'h41);
    acc_log.delete();
    wait_count(1, 20);
    chk("t2_count", 32'(fifo_count), 1);
    chk("t2_reads", acc_log.size(), 1);
    tbr_en = 1'b1;
    out_log.delete();
    wait_out(1, 20);
    chk("t2_out_n", out_log.size(), 1);
    if (out_log.size() == 1) chk("t2_out", 32'(out_log[0]), 'h41);

    // Overflow: 9 bytes offered with the transmitter stalled
    tbr_en = 1'b0;
    run(3);
    out_log.delete();
    for (int i = 0; i < 9; i++) rx_q.push_back(8'(i));
    run(80);
    chk("t3_full", 32'(fifo_count), DEPTH);
    chk("t3_withheld", rx_q.size(), 1);
    tbr_en = 1'b1; busy_max = 3;
    wait_out(9, 300);
    chk("t3_out_n", out_log.size(), 9);
    for (int i = 0; i < out_log.size(); i++) chk("t3_order", 32'(out_log[i]), i);

    // Both sides ready: accesses alternate, starting opposite the last read
    tbr_en = 1'b0; busy_max = 0;
    run(6);
    for (int i = 0; i < 3; i++) rx_q.push_back(8'(8'h30 + i));
    wait_count(3, 40);
    chk("t4_buffered", 32'(fifo_count), 3);
    acc_log.delete();
    for (int i = 0; i < 10; i++) rx_q.push_back(8'(8'h50 + i));
    tbr_en = 1'b1;
    for (int i = 0; i < 60 && acc_log.size() < 8; i++) cyc();
    chk("t4_n", 32'(acc_log.size() >= 8), 1);
    if (acc_log.size() >= 8) begin
      chk("t4_first_w", 32'(acc_log[0]), 0);
      for (int i = 1; i < 8; i++) chk("t4_alt", 32'(acc_log[i] != acc_log[i-1]), 1);
    end
    for (int i = 0; i < 200 && (rx_q.size() > 0 || exp_q.size() > 0); i++) cyc();
    chk("t4_drained", 32'(fifo_count), 0);

    // Reset during a READ with 5 bytes buffered
    tbr_en = 1'b0;
    run(4);
    for (int i = 0; i < 6; i++) rx_q.push_back(8'(8'hA0 + i));
    wait_count(5, 60);
    chk("t5_buffered", 32'(fifo_count), 5);
    saw = 1'b0;
    for (int i = 0; i < 10 && !saw; i++) begin
      cyc();
      saw = bus.iocs && bus.iorw;
    end
    chk("t5_saw_read", 32'(saw), 1);
    rst = 1'b1;
    cyc();
    chk("t5_iocs", 32'(bus.iocs), 0);
    chk("t5_done", 32'(init_done), 0);
    rst = 1'b0;
    init_log.delete();
    run(4);
    chk("t5_redone", 32'(init_done), 1);
    chk_init("t5_init", 10'h28A, 10'h302);
    tbr_en = 1'b1;
    out_log.delete();
    wait_out(1, 40);
    chk("t5_out_n", out_log.size(), 1);
    if (out_log.size() == 1) chk("t5_kept", 32'(out_log[0]), 'hA5);

    // Baud change while idle with 2 bytes buffered
    rst = 1'b1; br_cfg = 2'd0;
    run(2);
    rst = 1'b0;
    init_log.delete();
    run(4);
    chk_init("init4800", 10'h215, 10'h305);
    tbr_en = 1'b0;
    run(3);
    rx_q.push_back(8'h11); rx_q.push_back(8'h22);
    wait_count(2, 30);
    chk("t6_buffered", 32'(fifo_count), 2);
    init_log.delete();
    br_cfg = 2'd3;
    run(20);
`ifdef BR_RECONFIG_EN
    chk_init("t6_reprog", 10'h2A2, 10'h300);
`else
    chk("t6_noprog", init_log.size(), 0);
`endif
    chk("t6_done", 32'(init_done), 1);
    tbr_en = 1'b1;
    out_log.delete();
    wait_out(2, 40);
    chk("t6_out_n", out_log.size(), 2);
    if (out_log.size() == 2) begin
      chk("t6_out0", 32'(out_log[0]), 'h11);
      chk("t6_out1", 32'(out_log[1]), 'h22);
    end

    // Randomized traffic against the model
    busy_max = 4;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(2) == 0 && rx_q.size() < 12) rx_q.push_back(8'($urandom));
      if ($urandom_range(49) == 0) tbr_en = ~tbr_en;
      cyc();
    end
    tbr_en = 1'b1;
    for (int i = 0; i < 600 && (rx_q.size() > 0 || exp_q.size() > 0); i++) cyc();
    chk("rand_rx_empty", rx_q.size(), 0);
    chk("rand_drained", 32'(fifo_count), 0);
    chk("rand_no_init", init_log.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
